rw_manager_ac_sequencer: RTL

Instruction fetch and issue stage that sits directly in front of the rw_manager AC instruction ROM (64 × 32, registered address plus registered data, 2-cycle read latency). It drives the ROM read address, tracks in-flight reads, buffers returned words in a small skid FIFO, and presents decoded address/command instructions downstream on a valid/ready handshake. Sequences start at a given ROM address and run until an instruction with the end flag set has been accepted.

---
 rtl/rw_manager_ac_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/rw_manager_ac_sequencer.sv
// Fetch/issue stage in front of the AC instruction ROM (2-cycle read latency).
// Define RW_MGR_AC_SEQ_CMD_COUNT_EN to build the accepted-instruction counter.
module rw_manager_ac_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ROM_AW     = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ROM_AW-1:0] start_addr,
  input  logic              abort,
  output logic [ROM_AW-1:0] rom_rdaddress,
  input  logic [31:0]       rom_q,
  output logic              ac_valid,
  input  logic              ac_ready,
  output logic              ac_end,
  output logic [11:0]       ac_cmd,
  output logic [15:0]       ac_addr,
  output logic              busy,
  output logic              done,
  output logic [15:0]       cmd_count,
  output logic [1:0]        dbg_state
);

  // Handshake: an instruction transfers on any cycle where ac_valid && ac_ready;
  // once raised, ac_valid and the decoded fields hold until that transfer.

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e            state_q;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              v1_q, v2_q;
  logic [2:0]        rep_q;
  logic [ROM_AW-1:0] rdaddr_q;
  logic              done_q;

  logic [31:0]       head;
  logic [CNT_W:0]    pend;
  logic              accept, pop, push, go, issue;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head   = mem_q[rd_ptr_q];
  assign accept = ac_valid && ac_ready;
  assign pop    = accept && (rep_q == head[31:29]);
  // Returns are kept only while still fetching; after the end word lands they are dropped.
  assign push   = v2_q && (state_q == S_FETCH);
  assign go     = start && !abort && (state_q == S_IDLE);
  assign pend   = {1'b0, count_q} + {{CNT_W{1'b0}}, v1_q} + {{CNT_W{1'b0}}, v2_q};
  assign issue  = (state_q == S_FETCH) && !abort && (pend < (CNT_W+1)'(FIFO_DEPTH));

  always_ff @(posedge clock) begin
    done_q <= 1'b0;
    if (reset || abort) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      rep_q    <= '0;
    end else begin
      v1_q <= go ? 1'b0 : issue;
      v2_q <= go ? 1'b0 : v1_q;
      case (state_q)
        S_IDLE:  if (go) state_q <= S_FETCH;
        S_FETCH: if (push && rom_q[28]) state_q <= S_DRAIN;
        S_DRAIN: begin
          if (pop && head[28]) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
        rep_q    <= '0;
      end else if (accept) begin
        rep_q <= rep_q + 3'd1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= rom_q;
  end

  // The ROM samples this address every cycle; it only advances on a credited read.
  always_ff @(posedge clock) begin
    if (reset)      rdaddr_q <= '0;
    else if (go)    rdaddr_q <= start_addr;
    else if (issue) rdaddr_q <= rdaddr_q + 1'b1;
  end

`ifdef RW_MGR_AC_SEQ_CMD_COUNT_EN
  logic [15:0] cmd_count_q;
  always_ff @(posedge clock) begin
    if (reset || go)                           cmd_count_q <= '0;
    else if (accept && cmd_count_q != 16'hFFFF) cmd_count_q <= cmd_count_q + 16'd1;
  end
  assign cmd_count = cmd_count_q;
`else
  assign cmd_count = '0;
`endif

  assign ac_valid      = (count_q != '0);
  assign ac_end        = ac_valid & head[28];
  assign ac_cmd        = ac_valid ? head[27:16] : '0;
  assign ac_addr       = ac_valid ? head[15:0] : '0;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign rom_rdaddress = rdaddr_q;
  assign dbg_state     = state_q;

endmodule
